dct_coef_serializer: RTL and testbench

DCT_COEF_SERIALIZER -- requirements
Module: dct_coef_serializer

---
 rtl/dct_pkg.sv | 12 +
 rtl/coef_threshold.sv | 20 ++
 rtl/dct_coef_serializer.sv | 120 ++++++++++++
 tb/tb_dct_coef_serializer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants and FSM state type for the DCT coefficient serializer.
package dct_pkg;

   localparam int unsigned COEF_W = 12;
   localparam int unsigned N_COEF = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/coef_threshold.sv
// Zeroes one signed coefficient whose magnitude is below the threshold.
module coef_threshold #(
   parameter int unsigned COEF_W = 12
) (
   input  logic signed [COEF_W-1:0] z,
   input  logic        [COEF_W-2:0] threshold,
   output logic signed [COEF_W-1:0] q
);

   logic signed [COEF_W:0] z_ext;
   logic        [COEF_W:0] mag;

   // One extra bit so the most negative value keeps its full magnitude.
   always_comb begin
      z_ext = {z[COEF_W-1], z};
      mag   = z_ext[COEF_W] ? $unsigned(-z_ext) : $unsigned(z_ext);
      q     = (mag < {2'b00, threshold}) ? '0 : z;
   end

endmodule

// File: rtl/dct_coef_serializer.sv
// Captures a thresholded frame of DCT coefficients and streams them out one per
// transfer over a valid/ready interface, reporting the frame's nonzero count.
module dct_coef_serializer
   import dct_pkg::*;
#(
   parameter int unsigned COEF_W = dct_pkg::COEF_W,
   parameter int unsigned N_COEF = dct_pkg::N_COEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_load,
   input  logic signed [COEF_W-1:0] in_z0,
   input  logic signed [COEF_W-1:0] in_z1,
   input  logic signed [COEF_W-1:0] in_z2,
   input  logic signed [COEF_W-1:0] in_z3,
   input  logic signed [COEF_W-1:0] in_z4,
   input  logic signed [COEF_W-1:0] in_z5,
   input  logic signed [COEF_W-1:0] in_z6,
   input  logic signed [COEF_W-1:0] in_z7,
   input  logic        [COEF_W-2:0] threshold,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [COEF_W-1:0] out_data,
   output logic        [2:0]        out_index,
   output logic                     out_last,
   output logic        [3:0]        nz_count
);

   localparam logic [2:0] LastIdx = 3'(N_COEF - 1);

   state_e                   state_q, state_d;
   logic [2:0]               idx_q, idx_d;
   logic                     load;
   logic signed [COEF_W-1:0] z_in   [N_COEF];
   logic signed [COEF_W-1:0] z_thr  [N_COEF];
   logic signed [COEF_W-1:0] coef_q [N_COEF];
   logic [3:0]               nz_q, nz_d;

   assign z_in[0] = in_z0;
   assign z_in[1] = in_z1;
   assign z_in[2] = in_z2;
   assign z_in[3] = in_z3;
   assign z_in[4] = in_z4;
   assign z_in[5] = in_z5;
   assign z_in[6] = in_z6;
   assign z_in[7] = in_z7;

   for (genvar i = 0; i < N_COEF; i++) begin : g_thr
      coef_threshold #(
         .COEF_W    (COEF_W)
      ) u_thr (
         .z         (z_in[i]),
         .threshold (threshold),
         .q         (z_thr[i])
      );
   end

   always_comb begin
      nz_d = '0;
      for (int i = 0; i < N_COEF; i++) begin
         if (z_thr[i] != '0) nz_d = nz_d + 4'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_load) begin
               state_d = SHIFT;
               idx_d   = '0;
               load    = 1'b1;
            end
         end
         SHIFT: begin
            if (out_ready) begin
               if (idx_q == LastIdx) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         nz_q    <= '0;
         for (int i = 0; i < N_COEF; i++) coef_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (load) begin
            nz_q <= nz_d;
            for (int i = 0; i < N_COEF; i++) coef_q[i] <= z_thr[i];
         end
      end
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == SHIFT);
      out_data  = out_valid ? coef_q[idx_q] : '0;
      out_index = idx_q;
      out_last  = out_valid && (idx_q == LastIdx);
      nz_count  = nz_q;
   end

endmodule

// File: tb/tb_dct_coef_serializer.sv
// Randomized bench for dct_coef_serializer against a frame-level reference model.
module tb_dct_coef_serializer;

   localparam int COEF_W = 12;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     in_load;
   logic signed [COEF_W-1:0] in_z [8];
   logic        [COEF_W-2:0] threshold;
   logic                     in_ready;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [COEF_W-1:0] out_data;
   logic        [2:0]        out_index;
   logic                     out_last;
   logic        [3:0]        nz_count;

   int n_total = 0;
   int n_pass  = 0;

   // Drain behaviour knobs shared by the scenario tasks.
   int ready_mode = 0;   // 0 always ready, 1 random, 2 stall 4 cycles at index 2
   bit garbage    = 0;   // pulse in_load with junk data during SHIFT
   bit hold_load  = 0;   // keep in_load high for back-to-back capture
   int abort_at   = -1;  // index at which reset is pulsed mid-frame
   int next_z [8];
   int next_thr;

   dct_coef_serializer #(
      .COEF_W    (COEF_W),
      .N_COEF    (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_load   (in_load),
      .in_z0     (in_z[0]),
      .in_z1     (in_z[1]),
      .in_z2     (in_z[2]),
      .in_z3     (in_z[3]),
      .in_z4     (in_z[4]),
      .in_z5     (in_z[5]),
      .in_z6     (in_z[6]),
      .in_z7     (in_z[7]),
      .threshold (threshold),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .nz_count  (nz_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int expv);
      n_total++;
      if (got == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
   endtask

   function automatic int ref_coef(input int z, input int thr);
      int m;
      m = (z < 0) ? -z : z;
      return (m < thr) ? 0 : z;
   endfunction

   task automatic model(input int z[8], input int thr, output int e[8], output int nz);
      nz = 0;
      for (int i = 0; i < 8; i++) begin
         e[i] = ref_coef(z[i], thr);
         if (e[i] != 0) nz++;
      end
   endtask

   function automatic int rand_coef();
      case ($urandom_range(0, 3))
         0:       return int'($urandom_range(0, 16)) - 8;
         1:       return int'($urandom_range(0, 4095)) - 2048;
         2:       return ($urandom_range(0, 1) != 0) ? -2048 : 2047;
         default: return int'($urandom_range(0, 80)) - 40;
      endcase
   endfunction

   task automatic gen(output int z[8], output int thr);
      for (int i = 0; i < 8; i++) z[i] = rand_coef();
      case ($urandom_range(0, 4))
         0:       thr = 0;
         1:       thr = 2047;
         default: thr = int'($urandom_range(1, 40));
      endcase
   endtask

   task automatic apply(input int z[8], input int thr);
      for (int i = 0; i < 8; i++) in_z[i] = COEF_W'(z[i]);
      threshold = (COEF_W-1)'(thr);
   endtask

   task automatic apply_rand();
      int z[8];
      int thr;
      for (int i = 0; i < 8; i++) z[i] = int'($urandom_range(0, 4095)) - 2048;
      thr = int'($urandom_range(0, 2047));
      apply(z, thr);
   endtask

   task automatic check_idle(input int exp_nz);
      check("idle_in_ready", in_ready, 1);
      check("idle_valid", out_valid, 0);
      check("idle_data", out_data, 0);
      check("idle_index", out_index, 0);
      check("idle_last", out_last, 0);
      check("idle_nz", nz_count, exp_nz);
   endtask

   task automatic do_abort();
      rst_n   = 1'b0;
      in_load = 1'b0;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_index", out_index, 0);
      check("rst_last", out_last, 0);
      check("rst_nz", nz_count, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("post_rst_valid", out_valid, 0);
         check("post_rst_data", out_data, 0);
      end
   endtask

   // Called at the negedge right after the capture edge.
   task automatic drain(input int expf[8], input int exp_nz);
      int k     = 0;
      int cyc   = 0;
      int stall = 0;
      bit rdy;
      while (k < 8 && cyc < 400) begin
         if (k == abort_at) begin
            do_abort();
            return;
         end
         check("valid", out_valid, 1);
         check("in_ready", in_ready, 0);
         check("data", out_data, expf[k]);
         check("index", out_index, k);
         check("last", out_last, int'(k == 7));
         check("nz", nz_count, exp_nz);
         case (ready_mode)
            0: rdy = 1'b1;
            1: rdy = 1'($urandom_range(0, 1));
            default: begin
               if (k == 2 && stall < 4) begin
                  rdy = 1'b0;
                  stall++;
               end else begin
                  rdy = 1'b1;
               end
            end
         endcase
         out_ready = rdy;
         if (hold_load) begin
            in_load = 1'b1;
            if (k == 7 && rdy) apply(next_z, next_thr);
            else apply_rand();
         end else if (garbage) begin
            if (k == 7 && rdy) begin
               in_load = 1'b0;
            end else begin
               in_load = 1'($urandom_range(0, 1));
               apply_rand();
            end
         end
         @(negedge clk);
         cyc++;
         if (rdy) k++;
      end
      if (k < 8) check("drain_timeout", k, 8);
   endtask

   task automatic run_frame(input int z[8], input int thr);
      int e[8];
      int nz;
      model(z, thr, e, nz);
      apply(z, thr);
      in_load = 1'b1;
      @(negedge clk);
      in_load = 1'b0;
      drain(e, nz);
      if (abort_at < 0) check_idle(nz);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int z[8];
      int thr;
      int e[8];
      int nz;

      rst_n     = 1'b1;
      in_load   = 1'b0;
      out_ready = 1'b0;
      threshold = '0;
      for (int i = 0; i < 8; i++) in_z[i] = '0;
      #2 rst_n = 1'b0;
      #1;
      check_idle(0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle(0);

      // Ramp 1..8, no thresholding.
      for (int i = 0; i < 8; i++) z[i] = i + 1;
      run_frame(z, 0);

      // Threshold boundaries including the most negative value.
      z = '{100, -3, 4, -5, 0, 2047, -2048, 5};
      run_frame(z, 5);

      // Backpressure at index 2.
      ready_mode = 2;
      gen(z, thr);
      run_frame(z, thr);

      // Loads and threshold changes during SHIFT are ignored.
      ready_mode = 1;
      garbage    = 1;
      for (int f = 0; f < 3; f++) begin
         gen(z, thr);
         run_frame(z, thr);
      end
      garbage = 0;

      // Reset pulsed mid-frame at index 4.
      ready_mode = 0;
      abort_at   = 4;
      gen(z, thr);
      run_frame(z, thr);
      abort_at = -1;
      check_idle(0);

      // Back-to-back capture with in_load held high.
      ready_mode = 1;
      hold_load  = 1;
      gen(z, thr);
      apply(z, thr);
      in_load = 1'b1;
      @(negedge clk);
      for (int f = 0; f < 4; f++) begin
         model(z, thr, e, nz);
         gen(next_z, next_thr);
         drain(e, nz);
         check_idle(nz);
         z   = next_z;
         thr = next_thr;
         if (f == 3) begin
            in_load   = 1'b0;
            hold_load = 0;
            @(negedge clk);
            check_idle(nz);
         end else begin
            @(negedge clk);
         end
      end

      // Random frames with random backpressure and junk loads.
      for (int f = 0; f < 20; f++) begin
         ready_mode = int'($urandom_range(0, 2));
         garbage    = 1'($urandom_range(0, 1));
         gen(z, thr);
         run_frame(z, thr);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
